// File: rtl/tmds_lane_serializer_if.sv
// Word-level valid/ready handshake into the multi-lane TMDS serializer.
interface tmds_lane_serializer_if #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 10
);

    logic [LANES*DATA_W-1:0] s_data;
    logic                    s_valid;
    logic                    s_ready;

    // Word source side (encoder / test driver)
    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    // Serializer side
    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/tmds_lane_serializer.sv
// Multi-lane DATA_W:2 gearbox feeding ODDR output primitives. One shared
// hold register takes words over valid/ready; every SLOTS cycles a word
// (hold, idle, training or tristate zeros) is loaded into per-lane shift
// registers and emitted as rise/fall bit pairs. DATA_W must be even and >= 4.
module tmds_lane_serializer #(
    parameter int unsigned       LANES     = 4,
    parameter int unsigned       DATA_W    = 10,
    parameter bit                LSB_FIRST = 1'b1,
    parameter logic [DATA_W-1:0] IDLE_WORD = 10'b1101010100
) (
    input  logic                     serial_clk,
    input  logic                     reset_n,
    tmds_lane_serializer_if.slave    s_if,
    input  logic [1:0]               mode,
    input  logic [LANES-1:0]         lane_invert,
    input  logic                     clr_underflow,
    output logic [LANES-1:0]         bit_rise,
    output logic [LANES-1:0]         bit_fall,
    output logic [LANES-1:0]         oe_n,
    output logic                     word_start,
    output logic [15:0]              underflow_cnt
);

    localparam int unsigned SLOTS  = DATA_W / 2;
    localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned WORD_W = LANES * DATA_W;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    localparam logic [1:0] MODE_NORMAL   = 2'b00;
    localparam logic [1:0] MODE_TRAINING = 2'b01;
    localparam logic [1:0] MODE_IDLE     = 2'b10;
    localparam logic [1:0] MODE_TRISTATE = 2'b11;

    // Training pattern: upper half ones, lower half zeros
    localparam logic [DATA_W-1:0] TRAIN_WORD = {{SLOTS{1'b1}}, {SLOTS{1'b0}}};

    // Reorder a word so that bit 0 is always the first bit on the wire;
    // the shift registers then only ever shift right by two.
    function automatic logic [DATA_W-1:0] wire_order(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = w;
        if (!LSB_FIRST) begin
            for (int i = 0; i < DATA_W; i++) begin
                r[i] = w[DATA_W-1-i];
            end
        end
        return r;
    endfunction

    // Flops
    logic [SLOT_W-1:0]              slot_cnt_q,      slot_cnt_d;
    logic [WORD_W-1:0]              hold_q,          hold_d;
    logic                           hold_valid_q,    hold_valid_d;
    logic [LANES-1:0][DATA_W-1:0]   shift_q,         shift_d;
    logic                           hiz_q,           hiz_d;
    logic [LANES-1:0]               bit_rise_q,      bit_rise_d;
    logic [LANES-1:0]               bit_fall_q,      bit_fall_d;
    logic [LANES-1:0]               oe_n_q,          oe_n_d;
    logic                           word_start_q,    word_start_d;
    logic [15:0]                    underflow_cnt_q, underflow_cnt_d;

    // Combinational helpers
    logic                           boundary_c;
    logic                           s_ready_c;
    logic                           accept_c;
    logic                           underflow_c;
    logic                           load_hiz_c;
    logic [LANES-1:0][DATA_W-1:0]   load_word_c;
    logic [LANES-1:0][DATA_W-1:0]   src_c;
    logic [LANES-1:0]               rise_raw_c;
    logic [LANES-1:0]               fall_raw_c;
    logic [LANES-1:0]               invert_c;

    // Handshake: hold can take a word when empty or being drained this edge
    always_comb begin
        boundary_c = (slot_cnt_q == LAST_SLOT);
        s_ready_c  = !hold_valid_q || boundary_c;
        accept_c   = s_if.s_valid && s_ready_c;
    end

    assign s_if.s_ready = s_ready_c;

    // Slot counter wraps every word
    always_comb begin
        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        if (boundary_c) begin
            slot_cnt_d = '0;
        end
    end

    // Hold register: always drained at a boundary, refilled on accept (no bypass)
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (accept_c) begin
            hold_d = s_if.s_data;
        end
        if (boundary_c) begin
            hold_valid_d = accept_c;
        end else if (accept_c) begin
            hold_valid_d = 1'b1;
        end
    end

    // Select the word loaded at the next boundary from the current mode
    always_comb begin
        load_word_c = '0;
        load_hiz_c  = 1'b0;
        underflow_c = 1'b0;
        case (mode)
            MODE_NORMAL: begin
                for (int k = 0; k < LANES; k++) begin
                    if (hold_valid_q) begin
                        load_word_c[k] = wire_order(hold_q[k*DATA_W +: DATA_W]);
                    end else begin
                        load_word_c[k] = wire_order(IDLE_WORD);
                    end
                end
                underflow_c = boundary_c && !hold_valid_q;
            end
            MODE_TRAINING: begin
                for (int k = 0; k < LANES; k++) begin
                    load_word_c[k] = wire_order(TRAIN_WORD);
                end
            end
            MODE_IDLE: begin
                for (int k = 0; k < LANES; k++) begin
                    load_word_c[k] = wire_order(IDLE_WORD);
                end
            end
            MODE_TRISTATE: begin
                load_hiz_c = 1'b1;
            end
            default: begin
                load_hiz_c = 1'b1;
            end
        endcase
    end

    // Shift registers and next output pair; slot 0 comes straight from the load word
    always_comb begin
        src_c      = '0;
        shift_d    = shift_q;
        rise_raw_c = '0;
        fall_raw_c = '0;
        hiz_d      = boundary_c ? load_hiz_c : hiz_q;
        for (int k = 0; k < LANES; k++) begin
            src_c[k]      = boundary_c ? load_word_c[k] : shift_q[k];
            shift_d[k]    = src_c[k] >> 2;
            rise_raw_c[k] = src_c[k][0];
            fall_raw_c[k] = src_c[k][1];
        end
        invert_c     = hiz_d ? '0 : lane_invert;
        bit_rise_d   = rise_raw_c ^ invert_c;
        bit_fall_d   = fall_raw_c ^ invert_c;
        oe_n_d       = {LANES{hiz_d}};
        word_start_d = boundary_c;
    end

    // Saturating underflow counter; a clear coinciding with an underflow leaves 1
    always_comb begin
        underflow_cnt_d = underflow_cnt_q;
        if (clr_underflow) begin
            underflow_cnt_d = underflow_c ? 16'd1 : 16'd0;
        end else if (underflow_c && (underflow_cnt_q != 16'hFFFF)) begin
            underflow_cnt_d = underflow_cnt_q + 16'd1;
        end
    end

    // State and output registers
    always_ff @(posedge serial_clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt_q      <= LAST_SLOT;
            hold_q          <= '0;
            hold_valid_q    <= 1'b0;
            shift_q         <= '0;
            hiz_q           <= 1'b1;
            bit_rise_q      <= '0;
            bit_fall_q      <= '0;
            oe_n_q          <= '1;
            word_start_q    <= 1'b0;
            underflow_cnt_q <= '0;
        end else begin
            slot_cnt_q      <= slot_cnt_d;
            hold_q          <= hold_d;
            hold_valid_q    <= hold_valid_d;
            shift_q         <= shift_d;
            hiz_q           <= hiz_d;
            bit_rise_q      <= bit_rise_d;
            bit_fall_q      <= bit_fall_d;
            oe_n_q          <= oe_n_d;
            word_start_q    <= word_start_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign bit_rise      = bit_rise_q;
    assign bit_fall      = bit_fall_q;
    assign oe_n          = oe_n_q;
    assign word_start    = word_start_q;
    assign underflow_cnt = underflow_cnt_q;

endmodule
